// File: rtl/cycle_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cycle_pkg
// Brief    : Shared widths and limits for the cycle-count sample path.
// Revision : 1.0 - initial release
// ============================================================================
package cycle_pkg;

    localparam int CYCLE_W            = 8;
    localparam int FIFO_DEPTH_DEFAULT = 4;
    localparam int DROP_CNT_W         = 8;
    localparam int DROP_CNT_MAX       = 255;

endpackage : cycle_pkg
`default_nettype wire

// File: rtl/fifo_ptr.sv
`default_nettype none
// ============================================================================
// Module   : fifo_ptr
// Brief    : Wrapping FIFO pointer with increment enable and async reset.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_ptr #(
    parameter int PTR_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    output logic [PTR_W-1:0] o_ptr
);

    logic [PTR_W-1:0] r_ptr;

    // Natural binary wrap of the full width keeps the extra MSB toggling
    // once per lap, which is what separates full from empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (i_inc) begin
            r_ptr <= r_ptr + PTR_W'(1);
        end
    end

    assign o_ptr = r_ptr;

endmodule : fifo_ptr
`default_nettype wire

// File: rtl/cycle_sample_fifo.sv
`default_nettype none
// ============================================================================
// Module   : cycle_sample_fifo
// Brief    : Small valid/ready FIFO buffering cycle-count samples.
//            Define DROP_CNT_EN to build the saturating rejected-write counter.
// Revision : 1.0 - initial release
// ============================================================================
module cycle_sample_fifo
    import cycle_pkg::*;
#(
    parameter  int DATA_W = CYCLE_W,
    parameter  int DEPTH  = FIFO_DEPTH_DEFAULT,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [DATA_W-1:0]     in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [DATA_W-1:0]     out_data,
    input  logic                  out_ready,
    output logic [ADDR_W:0]       count,
    output logic                  full,
    output logic                  empty,
    output logic [DROP_CNT_W-1:0] drop_cnt
);

    logic [ADDR_W:0]   w_wr_ptr;
    logic [ADDR_W:0]   w_rd_ptr;
    logic              w_wr_fire;
    logic              w_rd_fire;
    logic [DATA_W-1:0] r_mem [DEPTH];

    // Flags come purely from registered pointers; no same-cycle pass-through.
    assign full      = (w_wr_ptr[ADDR_W-1:0] == w_rd_ptr[ADDR_W-1:0]) &&
                       (w_wr_ptr[ADDR_W] != w_rd_ptr[ADDR_W]);
    assign empty     = (w_wr_ptr == w_rd_ptr);
    assign count     = w_wr_ptr - w_rd_ptr;
    assign in_ready  = !full;
    assign out_valid = !empty;

    assign w_wr_fire = in_valid && in_ready;
    assign w_rd_fire = out_valid && out_ready;

    fifo_ptr #(
        .PTR_W (ADDR_W + 1)
    ) u_wr_ptr (
        .clk   (clk),
        .rst   (rst),
        .i_inc (w_wr_fire),
        .o_ptr (w_wr_ptr)
    );

    fifo_ptr #(
        .PTR_W (ADDR_W + 1)
    ) u_rd_ptr (
        .clk   (clk),
        .rst   (rst),
        .i_inc (w_rd_fire),
        .o_ptr (w_rd_ptr)
    );

    // Storage is intentionally left uncleared by reset.
    always_ff @(posedge clk) begin
        if (w_wr_fire) begin
            r_mem[w_wr_ptr[ADDR_W-1:0]] <= in_data;
        end
    end

    assign out_data = r_mem[w_rd_ptr[ADDR_W-1:0]];

`ifdef DROP_CNT_EN
    logic [DROP_CNT_W-1:0] r_drop_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_drop_cnt <= '0;
        end else if (in_valid && full &&
                     (r_drop_cnt != DROP_CNT_W'(DROP_CNT_MAX))) begin
            r_drop_cnt <= r_drop_cnt + DROP_CNT_W'(1);
        end
    end

    assign drop_cnt = r_drop_cnt;
`else
    assign drop_cnt = '0;
`endif

endmodule : cycle_sample_fifo
`default_nettype wire

// File: tb/tb_cycle_sample_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_cycle_sample_fifo
// Brief    : Directed vector bench for cycle_sample_fifo.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cycle_sample_fifo;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic [2:0] count;
    logic       full;
    logic       empty;
    logic [7:0] drop_cnt;

    int checks = 0;
    int errors = 0;

    cycle_sample_fifo u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .drop_cnt  (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       iv;
        logic [7:0] id;
        logic       ordy;
        logic       ov;
        logic [7:0] od;
        logic [2:0] cnt;
        logic       fl;
        logic       em;
        logic       ir;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = 8'h00;
        out_ready = 1'b0;
        #2;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic fill4();
        out_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            in_valid = 1'b1;
            in_data = 8'(k);
            step();
        end
        in_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_drop;

        tbl[0]  = '{1'b0, 8'd0,  1'b0, 1'b0, 8'd0,  3'd0, 1'b0, 1'b1, 1'b1};
        tbl[1]  = '{1'b1, 8'd1,  1'b0, 1'b1, 8'd1,  3'd1, 1'b0, 1'b0, 1'b1};
        tbl[2]  = '{1'b1, 8'd2,  1'b0, 1'b1, 8'd1,  3'd2, 1'b0, 1'b0, 1'b1};
        tbl[3]  = '{1'b1, 8'd3,  1'b0, 1'b1, 8'd1,  3'd3, 1'b0, 1'b0, 1'b1};
        tbl[4]  = '{1'b1, 8'd4,  1'b0, 1'b1, 8'd1,  3'd4, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 8'd5,  1'b0, 1'b1, 8'd1,  3'd4, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 8'd0,  1'b1, 1'b1, 8'd2,  3'd3, 1'b0, 1'b0, 1'b1};
        tbl[7]  = '{1'b0, 8'd0,  1'b1, 1'b1, 8'd3,  3'd2, 1'b0, 1'b0, 1'b1};
        tbl[8]  = '{1'b0, 8'd0,  1'b1, 1'b1, 8'd4,  3'd1, 1'b0, 1'b0, 1'b1};
        tbl[9]  = '{1'b0, 8'd0,  1'b1, 1'b0, 8'd0,  3'd0, 1'b0, 1'b1, 1'b1};
        tbl[10] = '{1'b1, 8'd9,  1'b1, 1'b1, 8'd9,  3'd1, 1'b0, 1'b0, 1'b1};
        tbl[11] = '{1'b1, 8'd10, 1'b1, 1'b1, 8'd10, 3'd1, 1'b0, 1'b0, 1'b1};

        // Reset values, held in reset and after release.
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = 8'h00;
        out_ready = 1'b0;
        #2;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Table: fill, reject 5th, drain, then empty/steady read-write cases.
        for (int i = 0; i < 12; i++) begin
            in_valid = tbl[i].iv;
            in_data = tbl[i].id;
            out_ready = tbl[i].ordy;
            step();
            chk($sformatf("v%0d_count", i), 32'(count), 32'(tbl[i].cnt));
            chk($sformatf("v%0d_full", i), 32'(full), 32'(tbl[i].fl));
            chk($sformatf("v%0d_empty", i), 32'(empty), 32'(tbl[i].em));
            chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].ir));
            chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].ov));
            if (tbl[i].ov) begin
                chk($sformatf("v%0d_out_data", i), 32'(out_data), 32'(tbl[i].od));
            end
        end
`ifdef DROP_CNT_EN
        exp_drop = 8'd1;
`else
        exp_drop = 8'd0;
`endif
        chk("drop_after_reject", 32'(drop_cnt), 32'(exp_drop));

        // Streaming 0..19 after one priming write: count stays 1, one-cycle delay.
        do_reset();
        in_valid = 1'b1;
        in_data = 8'd0;
        out_ready = 1'b0;
        step();
        chk("stream_prime_count", 32'(count), 32'd1);
        for (int c = 1; c < 20; c++) begin
            in_data = 8'(c);
            out_ready = 1'b1;
            chk($sformatf("stream%0d_data", c), 32'(out_data), 32'(c - 1));
            step();
            chk($sformatf("stream%0d_count", c), 32'(count), 32'd1);
        end
        in_valid = 1'b0;
        chk("stream_last", 32'(out_data), 32'd19);
        step();
        chk("stream_drained", 32'(empty), 32'd1);

        // Full with simultaneous read: write must still be rejected.
        do_reset();
        fill4();
        in_valid = 1'b1;
        in_data = 8'h55;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("fullrd_count", 32'(count), 32'd3);
        chk("fullrd_data", 32'(out_data), 32'd2);
        step();
        chk("fullrd_data3", 32'(out_data), 32'd3);
        step();
        chk("fullrd_data4", 32'(out_data), 32'd4);
        step();
        chk("fullrd_empty", 32'(empty), 32'd1);
        chk("fullrd_ov", 32'(out_valid), 32'd0);
        out_ready = 1'b0;

        // Asynchronous reset mid-cycle with three entries stored.
        do_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_data = 8'(8'h30 + k);
            step();
        end
        in_valid = 1'b0;
        chk("arst_pre_count", 32'(count), 32'd3);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_ov", 32'(out_valid), 32'd0);
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_empty", 32'(empty), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b1;
        in_data = 8'hAA;
        step();
        in_valid = 1'b0;
        chk("arst_wr_count", 32'(count), 32'd1);
        chk("arst_wr_data", 32'(out_data), 32'hAA);

        // Hold full with in_valid for 300 cycles: saturation at 255.
        do_reset();
        fill4();
        in_valid = 1'b1;
        in_data = 8'hEE;
        for (int k = 0; k < 300; k++) begin
            step();
        end
`ifdef DROP_CNT_EN
        exp_drop = 8'd255;
`else
        exp_drop = 8'd0;
`endif
        chk("drop_sat", 32'(drop_cnt), 32'(exp_drop));
        step();
        step();
        chk("drop_sat_hold", 32'(drop_cnt), 32'(exp_drop));
        chk("drop_full_data", 32'(out_data), 32'd1);
        in_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_cycle_sample_fifo
`default_nettype wire
